mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Main control FSM of the multicycle RV32I core. Sequences one instruction per FETCH..writeback
//  pass, driving datapath mux selects, IR/PC/RF/memory enables and alu_op[1:0] to ALUControl.
//  Sits beside the datapath; consumes opcode, ALU branch condition and memory ready handshake.
// PARAMETERS
//  CNT_W         32  width of retired-instruction counter instret
//  ILLEGAL_HALT  0   1: unknown opcode -> HALT (sticky until rst); 0: pulse illegal_instr, go FETCH
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      synchronous, active-high reset
//  opcode         in   7      IR[6:0], valid from DECODE onward
//  alu_cond       in   1      ALU compare result (branch taken) for current alu_op/func3
//  mem_ready      in   1      memory accepts/finishes the access this cycle
//  mem_req        out  1      memory access request (FETCH, MEMREAD, MEMWRITE)
//  mem_write      out  1      store strobe, only with mem_req in MEMWRITE
//  adr_src        out  1      0: address=PC, 1: address=ALUOut
//  ir_write       out  1      latch IR and OldPC
//  pc_write       out  1      latch PC from result bus
//  reg_write      out  1      register file write enable
//  alu_src_a      out  2      00 PC, 01 OldPC, 10 rs1 reg A, 11 zero
//  alu_src_b      out  2      00 rs2 reg B, 01 immediate, 10 const 4
//  result_src     out  2      00 ALUOut, 01 memory data reg, 10 ALU result (unregistered)
//  alu_op         out  2      00 add, 01 branch, 10 R-type, 11 I-type (ALUControl encoding)
//  illegal_instr  out  1      1-cycle pulse in DECODE on unknown opcode
//  halted         out  1      1 while in HALT
//  state_dbg      out  4      current state encoding
//  instret        out  CNT_W  retired instruction count
// BEHAVIOUR
//  - Moore outputs from state except ir_write/pc_write gated by mem_ready/alu_cond as below.
//  - rst=1: state<=FETCH, instret<=0; while rst=1 all enables (mem_req, mem_write, ir_write,
//    pc_write, reg_write) forced 0, selects 0, illegal_instr=0, halted=0. Mid-instruction reset
//    abandons the instruction, no write issued. Unlisted outputs per state are 0.
//  - FETCH: adr_src=0 mem_req=1 a=00 b=10 op=00 res=10; ir_write=pc_write=mem_ready;
//    stay while !mem_ready, else DECODE. Minimum latency 1 cycle per access.
//  - DECODE: a=01 b=01 op=00 (ALUOut<=OldPC+imm). Next by opcode: 0000011/0100011->MEMADR,
//    0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, 1100111->JALR_ADR,
//    0110111->LUI, 0010111->ALUWB, other->illegal (FETCH or HALT per ILLEGAL_HALT).
//  - MEMADR: a=10 b=01 op=00; load->MEMREAD, store->MEMWRITE.
//  - MEMREAD: adr_src=1 mem_req=1; wait mem_ready -> MEMWB.  MEMWB: res=01 reg_write -> FETCH.
//  - MEMWRITE: adr_src=1 mem_req=1 mem_write=1; wait mem_ready -> FETCH.
//  - EXECR: a=10 b=00 op=10 -> ALUWB.  EXECI: a=10 b=01 op=11 -> ALUWB.  LUI: a=11 b=01 -> ALUWB.
//  - ALUWB: res=00 reg_write -> FETCH.
//  - BRANCH: a=10 b=00 op=01 res=00; pc_write=alu_cond -> FETCH (target from DECODE ALUOut).
//  - JAL: a=01 b=10 op=00 res=00 pc_write -> ALUWB (PC<=target, then rd<=OldPC+4).
//  - JALR_ADR: a=10 b=01 op=00 -> JALR_PC.  JALR_PC: a=01 b=10 res=00 pc_write -> ALUWB.
//  - HALT: halted=1, all enables 0, held until rst.
//  - instret +1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH; not on
//    illegal. Wraps modulo 2^CNT_W. mem_ready ignored outside FETCH/MEMREAD/MEMWRITE.
//  - State register sampled only on clk edge; no combinational path opcode->next state
//    outputs other than via registered state.
// STRUCTURE
//  - Package mc_ctrl_pkg: state_t enum (15 states, 4b), opcode localparams, alu_op_t,
//    src_a_t/src_b_t/result_src_t encodings; shared with datapath and ALUControl bench.
//  - Sub-module mc_opcode_decode (combinational): opcode -> instruction class + legal flag.
//  - Top: state register, next-state case, output case, instret counter.
// TESTING
//  - ADD (0110011), mem_ready=1: states FETCH,DECODE,EXECR,ALUWB; alu_op=10 in EXECR,
//    reg_write=1 only in ALUWB; instret 0->1; 4 cycles.
//  - LW with mem_ready low 3 cycles in MEMREAD: mem_req/adr_src=1 held 4 cycles,
//    reg_write only in MEMWB with result_src=01; total 5+3 cycles.
//  - BEQ alu_cond=0 then =1: pc_write=0 vs 1 in BRANCH, alu_op=01; both retire.
//  - JALR: JALR_ADR a=10 b=01, JALR_PC pc_write=1 res=00, ALUWB reg_write=1.
//  - opcode 7'h7F: illegal_instr 1-cycle pulse, FETCH next, instret unchanged; with
//    ILLEGAL_HALT=1 halted=1 and stays until rst.
//  - rst=1 asserted in MEMWRITE while mem_ready=0: next cycle state FETCH, mem_write never
//    seen high with mem_ready=1, instret=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: states, opcodes and
// datapath select values used by the controller, datapath and ALUControl.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR_ADR = 4'd11,
    S_JALR_PC  = 4'd12,
    S_LUI      = 4'd13,
    S_HALT     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {ALU_ADD, ALU_BRANCH, ALU_RTYPE, ALU_ITYPE} alu_op_t;
  typedef enum logic [1:0] {SRC_A_PC, SRC_A_OLDPC, SRC_A_RS1, SRC_A_ZERO} src_a_t;
  typedef enum logic [1:0] {SRC_B_RS2, SRC_B_IMM, SRC_B_FOUR} src_b_t;
  typedef enum logic [1:0] {RES_ALUOUT, RES_MEMDATA, RES_ALU} result_src_t;

  typedef enum logic [3:0] {
    CLS_LOAD, CLS_STORE, CLS_RTYPE, CLS_ITYPE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier: maps IR[6:0] to an instruction class and
// flags opcodes the core does not implement.
module mc_opcode_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0]   opcode_i,
  output instr_class_t class_o,
  output logic         legal_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    class_o = CLS_ILLEGAL;
    case (opcode_i)
      OP_LOAD:   class_o = CLS_LOAD;
      OP_STORE:  class_o = CLS_STORE;
      OP_RTYPE:  class_o = CLS_RTYPE;
      OP_ITYPE:  class_o = CLS_ITYPE;
      OP_BRANCH: class_o = CLS_BRANCH;
      OP_JAL:    class_o = CLS_JAL;
      OP_JALR:   class_o = CLS_JALR;
      OP_LUI:    class_o = CLS_LUI;
      OP_AUIPC:  class_o = CLS_AUIPC;
      default:   class_o = CLS_ILLEGAL;
    endcase
    legal_o = (class_o != CLS_ILLEGAL);
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences FETCH..writeback,
// drives datapath selects/enables and counts retired instructions.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned ILLEGAL_HALT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             alu_cond,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic             illegal_instr,
  output logic             halted,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  instr_class_t     op_class;
  logic             op_legal;
  logic             retire;
  src_a_t           src_a;
  src_b_t           src_b;
  result_src_t      res_src;
  alu_op_t          op_sel;

  mc_opcode_decode u_decode (
    .opcode_i (opcode),
    .class_o  (op_class),
    .legal_o  (op_legal)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (!op_legal) begin
          state_d = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
        end else begin
          case (op_class)
            CLS_LOAD, CLS_STORE: state_d = S_MEMADR;
            CLS_RTYPE:           state_d = S_EXECR;
            CLS_ITYPE:           state_d = S_EXECI;
            CLS_BRANCH:          state_d = S_BRANCH;
            CLS_JAL:             state_d = S_JAL;
            CLS_JALR:            state_d = S_JALR_ADR;
            CLS_LUI:             state_d = S_LUI;
            default:             state_d = S_ALUWB;
          endcase
        end
      end
      S_MEMADR:   state_d = (op_class == CLS_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_LUI, S_JAL, S_JALR_PC: state_d = S_ALUWB;
      S_ALUWB, S_BRANCH: state_d = S_FETCH;
      S_JALR_ADR: state_d = S_JALR_PC;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // Reset forces every enable and select low regardless of the held state.
  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    halted        = 1'b0;
    src_a         = SRC_A_PC;
    src_b         = SRC_B_RS2;
    res_src       = RES_ALUOUT;
    op_sel        = ALU_ADD;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          src_b    = SRC_B_FOUR;
          res_src  = RES_ALU;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_DECODE: begin
          src_a         = SRC_A_OLDPC;
          src_b         = SRC_B_IMM;
          illegal_instr = !op_legal;
        end
        S_MEMADR, S_JALR_ADR: begin
          src_a = SRC_A_RS1;
          src_b = SRC_B_IMM;
        end
        S_MEMREAD: begin
          adr_src = 1'b1;
          mem_req = 1'b1;
        end
        S_MEMWB: begin
          res_src   = RES_MEMDATA;
          reg_write = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src   = 1'b1;
          mem_req   = 1'b1;
          mem_write = 1'b1;
        end
        S_EXECR: begin
          src_a  = SRC_A_RS1;
          op_sel = ALU_RTYPE;
        end
        S_EXECI: begin
          src_a  = SRC_A_RS1;
          src_b  = SRC_B_IMM;
          op_sel = ALU_ITYPE;
        end
        S_LUI: begin
          src_a = SRC_A_ZERO;
          src_b = SRC_B_IMM;
        end
        S_ALUWB:  reg_write = 1'b1;
        S_BRANCH: begin
          src_a    = SRC_A_RS1;
          op_sel   = ALU_BRANCH;
          pc_write = alu_cond;
        end
        S_JAL, S_JALR_PC: begin
          src_a    = SRC_A_OLDPC;
          src_b    = SRC_B_FOUR;
          pc_write = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH});

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign alu_src_a  = src_a;
  assign alu_src_b  = src_b;
  assign result_src = res_src;
  assign alu_op     = op_sel;
  assign state_dbg  = state_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: each instruction is expanded into its
// expected per-cycle phase list and compared cycle by cycle.
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = '0;
  logic        alu_cond = 1'b0;
  logic        mem_ready = 1'b0;

  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, result_src, alu_op;
  logic        illegal_instr, halted;
  logic [3:0]  state_dbg;
  logic [31:0] instret;

  logic        h_mem_req, h_mem_write, h_adr_src, h_ir_write, h_pc_write, h_reg_write;
  logic [1:0]  h_alu_src_a, h_alu_src_b, h_result_src, h_alu_op;
  logic        h_illegal_instr, h_halted;
  logic [3:0]  h_state_dbg;
  logic [31:0] h_instret;

  always #5 clk = ~clk;

  mc_control_fsm u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_cond(alu_cond), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
    .illegal_instr(illegal_instr), .halted(halted), .state_dbg(state_dbg),
    .instret(instret)
  );

  mc_control_fsm #(.ILLEGAL_HALT(1)) u_hlt (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_cond(alu_cond), .mem_ready(mem_ready),
    .mem_req(h_mem_req), .mem_write(h_mem_write), .adr_src(h_adr_src),
    .ir_write(h_ir_write), .pc_write(h_pc_write), .reg_write(h_reg_write),
    .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b), .result_src(h_result_src),
    .alu_op(h_alu_op), .illegal_instr(h_illegal_instr), .halted(h_halted),
    .state_dbg(h_state_dbg), .instret(h_instret)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Packed view of the default instance's outputs (instret checked separately).
  function automatic logic [31:0] obs();
    return {12'd0, halted, illegal_instr, alu_op, result_src, alu_src_b, alu_src_a,
            reg_write, pc_write, ir_write, adr_src, mem_write, mem_req, state_dbg};
  endfunction

  function automatic logic [31:0] row(state_t st, bit req, bit mw, bit adr, bit irw,
                                      bit pcw, bit rw, logic [1:0] a, logic [1:0] b,
                                      logic [1:0] res, logic [1:0] op, bit ill);
    return {12'd0, 1'b0, ill, op, res, b, a, rw, pcw, irw, adr, mw, req, st};
  endfunction

  typedef struct {
    logic [31:0] exp;
    bit          rdy;
    bit          cond;
    logic [6:0]  opc;
  } step_t;

  step_t       trace[$];
  int unsigned model_instret = 0;

  function automatic bit is_legal(logic [6:0] o);
    return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                     7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  endfunction

  // rdy/cond: 0 or 1 fixed, 2 means don't-care (randomized).
  task automatic push(input logic [31:0] e, input int r, input int c, input logic [6:0] o);
    step_t s;
    s.exp  = e;
    s.rdy  = (r == 2) ? bit'($urandom_range(0, 1)) : bit'(r);
    s.cond = (c == 2) ? bit'($urandom_range(0, 1)) : bit'(c);
    s.opc  = o;
    trace.push_back(s);
  endtask

  task automatic build(input logic [6:0] o, input bit cond, input int fw, input int mwait);
    trace.delete();
    for (int i = 0; i < fw; i++)
      push(row(S_FETCH, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0), 0, 2, 7'($urandom));
    push(row(S_FETCH, 1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0), 1, 2, 7'($urandom));
    push(row(S_DECODE, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, !is_legal(o)), 2, 2, o);
    case (o)
      7'b0000011: begin
        push(row(S_MEMADR, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0), 2, 2, o);
        for (int i = 0; i < mwait; i++)
          push(row(S_MEMREAD, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 0, 2, o);
        push(row(S_MEMREAD, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1, 2, o);
        push(row(S_MEMWB, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00, 0), 2, 2, o);
      end
      7'b0100011: begin
        push(row(S_MEMADR, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0), 2, 2, o);
        for (int i = 0; i < mwait; i++)
          push(row(S_MEMWRITE, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 0, 2, o);
        push(row(S_MEMWRITE, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1, 2, o);
      end
      7'b0110011: push(row(S_EXECR, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 0), 2, 2, o);
      7'b0010011: push(row(S_EXECI, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b11, 0), 2, 2, o);
      7'b0110111: push(row(S_LUI, 0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b00, 2'b00, 0), 2, 2, o);
      7'b1101111: push(row(S_JAL, 0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0), 2, 2, o);
      7'b1100111: begin
        push(row(S_JALR_ADR, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0), 2, 2, o);
        push(row(S_JALR_PC, 0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0), 2, 2, o);
      end
      7'b1100011:
        push(row(S_BRANCH, 0, 0, 0, 0, cond, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0), 2, int'(cond), o);
      default: ;
    endcase
    // Every non-branch, non-memory legal class finishes through ALU writeback.
    if (is_legal(o) && !(o inside {7'b0000011, 7'b0100011, 7'b1100011}))
      push(row(S_ALUWB, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0), 2, 2, o);
  endtask

  task automatic run(input string name, input logic [6:0] o, input bit cond,
                     input int fw, input int mwait, input int limit);
    build(o, cond, fw, mwait);
    foreach (trace[i]) begin
      if (limit >= 0 && i >= limit) break;
      @(negedge clk);
      mem_ready = trace[i].rdy;
      alu_cond  = trace[i].cond;
      opcode    = trace[i].opc;
      #1;
      check($sformatf("%s.out%0d", name, i), obs(), trace[i].exp);
      check($sformatf("%s.instret%0d", name, i), instret, model_instret);
    end
    if (limit < 0 && is_legal(o)) model_instret++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("rst.out", obs(), 32'd0);
    check("rst.instret", instret, 32'd0);
    check("rst.h_halted", {31'd0, h_halted}, 32'd0);
    rst = 1'b0;
    model_instret = 0;
  endtask

  logic [6:0] legal_ops[9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    do_reset();

    run("add", 7'b0110011, 1'b0, 0, 0, -1);
    run("lw", 7'b0000011, 1'b0, 0, 3, -1);
    run("beq0", 7'b1100011, 1'b0, 0, 0, -1);
    run("beq1", 7'b1100011, 1'b1, 0, 0, -1);
    run("jalr", 7'b1100111, 1'b0, 1, 0, -1);
    run("ill", 7'h7F, 1'b0, 0, 0, -1);
    run("after_ill", 7'b0110111, 1'b0, 0, 0, -1);

    // Abort a store stalled in MEMWRITE: no write and a clean counter afterwards.
    run("sw_abort", 7'b0100011, 1'b0, 0, 5, 5);
    @(negedge clk);
    rst       = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("abort.outs", obs() & ~32'hF, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("abort.state", {28'd0, state_dbg}, {28'd0, S_FETCH});
    check("abort.instret", instret, 32'd0);
    model_instret = 0;

    // Halting instance: sticky HALT after an unknown opcode until reset.
    do_reset();
    run("hlt", 7'h7F, 1'b0, 0, 0, -1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      opcode    = 7'b0110011;
      #1;
      check($sformatf("hlt.halted%0d", i), {31'd0, h_halted}, 32'd1);
      check($sformatf("hlt.state%0d", i), {28'd0, h_state_dbg}, {28'd0, S_HALT});
      check($sformatf("hlt.enables%0d", i),
            {26'd0, h_mem_req, h_mem_write, h_ir_write, h_pc_write, h_reg_write, h_illegal_instr},
            32'd0);
    end
    do_reset();

    for (int n = 0; n < 300; n++) begin
      logic [6:0] o;
      if ($urandom_range(0, 9) == 0) o = 7'($urandom);
      else o = legal_ops[$urandom_range(0, 8)];
      run($sformatf("rnd%0d", n), o, bit'($urandom_range(0, 1)),
          int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("final.instret", instret, model_instret);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
